// File: rtl/lfsr_draw_arbiter.sv
// Round-robin arbiter sharing one 8-bit LFSR among N_REQ clients; each winner
// receives one fresh 3-bit draw after STEPS_PER_DRAW LFSR shifts.
module lfsr_draw_arbiter #(
  parameter int N_REQ          = 4,
  parameter int STEPS_PER_DRAW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rnd_valid,
  output logic [2:0]       rnd_data,
  input  logic             seed_req,
  input  logic [7:0]       seed_val,
  output logic             seed_done,
  output logic             busy,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic [7:0]       lfsr_seed,
  input  logic [2:0]       lfsr_rout,
  output logic [1:0]       state_dbg
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [3:0] LAST_STEP = 4'(STEPS_PER_DRAW - 1);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    STEP    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] pick;
  logic             pick_vld;
  logic [3:0]       step_cnt;
  logic [7:0]       seed_q;

  // Rotating priority scan: the client just after the last winner goes first.
  always_comb begin : scan
    int               idx;
    logic [PTR_W-1:0] cand;
    idx      = 0;
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PTR_W'(idx);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Seed requests take precedence over pending draws whenever IDLE is reached.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (seed_req)      state_nxt = LOAD;
        else if (pick_vld) state_nxt = STEP;
      end
      LOAD:    state_nxt = IDLE;
      STEP:    if (step_cnt == LAST_STEP) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= PTR_RST;
      winner   <= '0;
      step_cnt <= '0;
      seed_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_req) begin
            seed_q <= seed_val;
          end else if (pick_vld) begin
            winner   <= pick;
            step_cnt <= '0;
          end
        end
        STEP:    step_cnt <= step_cnt + 4'd1;
        DELIVER: ptr <= winner;
        default: ;
      endcase
    end
  end

  // All control outputs decode the state register only, so load and en are
  // mutually exclusive by construction.
  assign lfsr_load = (state == LOAD);
  assign seed_done = (state == LOAD);
  assign lfsr_en   = (state == STEP);
  assign rnd_valid = (state == DELIVER);
  assign busy      = (state != IDLE);
  assign lfsr_seed = seed_q;
  assign rnd_data  = rnd_valid ? lfsr_rout : 3'b000;
  assign state_dbg = state;

  always_comb begin
    gnt = '0;
    if (rnd_valid) gnt[winner] = 1'b1;
  end

endmodule

// File: tb/tb_lfsr_draw_arbiter.sv
// Bench for lfsr_draw_arbiter: directed vector table, mid-draw reset, a
// STEPS_PER_DRAW=3 instance, and random traffic against a transaction model.
module tb_lfsr_draw_arbiter;

  localparam int N     = 4;
  localparam int STEPS = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (STEPS_PER_DRAW = 1)
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         rnd_valid, seed_done, busy, lfsr_load, lfsr_en;
  logic [2:0]   rnd_data, lfsr_rout;
  logic         seed_req = 1'b0;
  logic [7:0]   seed_val = 8'h00;
  logic [7:0]   lfsr_seed;
  logic [1:0]   state_dbg;

  lfsr_draw_arbiter #(.N_REQ(N), .STEPS_PER_DRAW(STEPS)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
    .rnd_data(rnd_data), .seed_req(seed_req), .seed_val(seed_val),
    .seed_done(seed_done), .busy(busy), .lfsr_load(lfsr_load),
    .lfsr_en(lfsr_en), .lfsr_seed(lfsr_seed), .lfsr_rout(lfsr_rout),
    .state_dbg(state_dbg)
  );

  // second DUT (STEPS_PER_DRAW = 3)
  logic [N-1:0] req3 = '0;
  logic [N-1:0] gnt3;
  logic         rnd_valid3, seed_done3, busy3, lfsr_load3, lfsr_en3;
  logic [2:0]   rnd_data3, lfsr_rout3;
  logic [7:0]   lfsr_seed3;
  logic [1:0]   state_dbg3;

  lfsr_draw_arbiter #(.N_REQ(N), .STEPS_PER_DRAW(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .gnt(gnt3), .rnd_valid(rnd_valid3),
    .rnd_data(rnd_data3), .seed_req(1'b0), .seed_val(8'h00),
    .seed_done(seed_done3), .busy(busy3), .lfsr_load(lfsr_load3),
    .lfsr_en(lfsr_en3), .lfsr_seed(lfsr_seed3), .lfsr_rout(lfsr_rout3),
    .state_dbg(state_dbg3)
  );

  // 8-bit LFSR: 01->02->05->0A->15->2B->56->AC, r_out={s[6],s[3],s[0]}
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[1]};
  endfunction

  function automatic logic [2:0] rout_of(input logic [7:0] s);
    return {s[6], s[3], s[0]};
  endfunction

  // external LFSR instances (en has priority over load, seed 0 becomes 1)
  logic [7:0] env_s, env_s3;
  always @(posedge clk or posedge rst) begin
    if (rst)            env_s <= 8'h01;
    else if (lfsr_en)   env_s <= lfsr_next(env_s);
    else if (lfsr_load) env_s <= (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
  end
  always @(posedge clk or posedge rst) begin
    if (rst)             env_s3 <= 8'h01;
    else if (lfsr_en3)   env_s3 <= lfsr_next(env_s3);
    else if (lfsr_load3) env_s3 <= (lfsr_seed3 == 8'h00) ? 8'h01 : lfsr_seed3;
  end
  assign lfsr_rout  = rout_of(env_s);
  assign lfsr_rout3 = rout_of(env_s3);

  // scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transaction-level reference model
  logic [6:0] exp_q[$];     // {gnt, rnd_data} per accepted draw
  int         m_busy;       // cycles of activity still ahead
  logic       m_is_draw;
  int         m_ptr;
  logic [7:0] m_lfsr;
  logic [7:0] m_seed;

  task automatic model_reset();
    m_busy    = 0;
    m_is_draw = 1'b0;
    m_ptr     = N - 1;
    m_lfsr    = 8'h01;
    m_seed    = 8'h00;
    exp_q.delete();
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    int w;
    if (rst) begin
      model_reset();
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (seed_req) begin
      m_is_draw = 1'b0;
      m_seed    = seed_val;
      m_lfsr    = (seed_val == 8'h00) ? 8'h01 : seed_val;
      m_busy    = 1;
    end else if (req != '0) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_ptr = w;
      for (int s = 0; s < STEPS; s++) m_lfsr = lfsr_next(m_lfsr);
      exp_q.push_back({4'(1 << w), rout_of(m_lfsr)});
      m_is_draw = 1'b1;
      m_busy    = STEPS + 1;
    end
  endtask

  task automatic compare();
    logic [6:0] ev;
    logic       exp_valid, exp_sd, exp_en;
    ev        = '0;
    exp_valid = (m_busy == 1) && m_is_draw;
    exp_sd    = (m_busy == 1) && !m_is_draw;
    exp_en    = (m_busy > 1) && m_is_draw;
    if (exp_valid) begin
      if (exp_q.size() > 0) ev = exp_q.pop_front();
      else check("exp_q_underflow", 32'd0, 32'd1);
    end
    check("gnt", 32'(gnt), 32'(ev[6:3]));
    check("rnd_valid", 32'(rnd_valid), 32'(exp_valid));
    check("rnd_data", 32'(rnd_data), 32'(ev[2:0]));
    check("seed_done", 32'(seed_done), 32'(exp_sd));
    check("lfsr_load", 32'(lfsr_load), 32'(exp_sd));
    check("lfsr_en", 32'(lfsr_en), 32'(exp_en));
    check("busy", 32'(busy), 32'(m_busy > 0));
    check("lfsr_seed", 32'(lfsr_seed), 32'(m_seed));
    check("load_en_excl", 32'(lfsr_load & lfsr_en), 32'd0);
  endtask

  // driver: one clock cycle with model prediction and output comparison
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_event(input int maxc, output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < maxc) begin
      cycle();
      lat++;
      if (gnt != '0 || seed_done) got = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic       seed_req;
    logic [7:0] seed_val;
    logic [3:0] exp_gnt;
    logic [2:0] exp_data;
    logic       exp_sd;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int         lat;
    logic       got;
    int         en_cnt;
    int         gcyc;

    vecs[0] = '{4'b0001, 1'b0, 8'h00, 4'b0001, 3'b000, 1'b0, 2};
    vecs[1] = '{4'b1111, 1'b0, 8'h00, 4'b0010, 3'b001, 1'b0, 3};
    vecs[2] = '{4'b1111, 1'b0, 8'h00, 4'b0100, 3'b010, 1'b0, 3};
    vecs[3] = '{4'b1111, 1'b0, 8'h00, 4'b1000, 3'b001, 1'b0, 3};
    vecs[4] = '{4'b1111, 1'b0, 8'h00, 4'b0001, 3'b011, 1'b0, 3};
    vecs[5] = '{4'b0100, 1'b1, 8'hAB, 4'b0000, 3'b000, 1'b1, 2};
    vecs[6] = '{4'b0100, 1'b0, 8'hAB, 4'b0100, 3'b101, 1'b0, 3};
    vecs[7] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 3'b000, 1'b1, 2};
    vecs[8] = '{4'b0001, 1'b0, 8'h00, 4'b0001, 3'b000, 1'b0, 3};

    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    check("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;

    // directed vector table
    for (int v = 0; v < 9; v++) begin
      req      = vecs[v].req;
      seed_req = vecs[v].seed_req;
      seed_val = vecs[v].seed_val;
      wait_event(20, lat, got);
      check($sformatf("vec%0d_event", v), 32'(got), 32'd1);
      check($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].exp_gnt));
      check($sformatf("vec%0d_data", v), 32'(rnd_data), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_seed_done", v), 32'(seed_done), 32'(vecs[v].exp_sd));
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
    end
    req      = '0;
    seed_req = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // reset in the middle of a draw
    req = 4'b0010;
    cycle();
    check("mid_step_en", 32'(lfsr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_en", 32'(lfsr_en), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_valid", 32'(rnd_valid), 32'd0);
    model_reset();
    req = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    req = 4'b1000;
    wait_event(20, lat, got);
    check("post_rst_event", 32'(got), 32'd1);
    check("post_rst_gnt", 32'(gnt), 32'(4'b1000));
    check("post_rst_data", 32'(rnd_data), 32'd0);
    req = '0;
    for (int i = 0; i < 3; i++) cycle();

    // STEPS_PER_DRAW = 3 instance
    req3   = 4'b0001;
    en_cnt = 0;
    gcyc   = 0;
    for (int c = 1; c <= 20 && gcyc == 0; c++) begin
      cycle();
      en_cnt += int'(lfsr_en3);
      if (gnt3 != '0) begin
        gcyc = c;
        check("s3_gnt", 32'(gnt3), 32'(4'b0001));
        check("s3_data", 32'(rnd_data3), 32'(3'b010));
      end
      req3 = '0;
    end
    check("s3_en_cycles", 32'(en_cnt), 32'd3);
    check("s3_gnt_cycle", 32'(gcyc), 32'd4);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (gnt[i])                                   req[i] = ($urandom_range(0, 2) == 0);
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && busy && $urandom_range(0, 30) == 0) req[i] = 1'b0;
      end
      if (seed_done) seed_req = 1'b0;
      else if (!seed_req && $urandom_range(0, 24) == 0) begin
        seed_req = 1'b1;
        seed_val = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) seed_val = 8'h00;
      end
    end
    req      = '0;
    seed_req = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
